mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
- Load/store unit: the initiator side of the CPU data-memory interface. It is driven by the MIPS datapath and drives mips_memory.
- Converts one MIPS load/store request into a single word-aligned memory transaction with big-endian byte lanes.
- For loads, captures the registered read data, then extracts, sign/zero-extends or merges (LWL/LWR) the result.
- Returns a one-cycle response pulse; misaligned accesses are flagged and never reach memory.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; fixed at 32, 4 byte lanes.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; returns block to IDLE
- req_valid  input  1  request strobe; sampled only while req_ready=1
- req_ready  output  1  high only in IDLE
- req_op  input  4  operation code, lsu_op_t
- req_addr  input  32  effective byte address
- req_wdata  input  32  store source (rt); SB/SH use low bits
- req_rt  input  32  current rt value, used by LWL/LWR merge
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  load result; 0 for stores and errors
- resp_err  output  1  misaligned or illegal op; valid with resp_valid
- mem_address  output  32  {req_addr[31:2],2'b00}
- mem_wr_en  output  1  write strobe to memory
- mem_read_en  output  1  read strobe to memory
- mem_byte_en  output  4  bit0 = addr+0 = data[31:24] … bit3 = addr+3 = data[7:0]
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read data, valid one cycle after mem_read_en sampled

Behaviour:
- Reset state: IDLE. All outputs are 0 except req_ready=1. Reset mid-operation aborts the transaction immediately; no response is issued. A memory write already sampled is not undone.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: when req_valid=1, latch op/addr/wdata/rt.
  - If the op is illegal or misaligned, go to DONE with err=1.
  - Otherwise go to ISSUE.
- ISSUE: the mem_* outputs are registered and driven for exactly this one cycle.
  - Loads: go to WAIT.
  - Stores: go to DONE.
- WAIT: memory output is now valid. Capture mem_rdata into the result register at the end of the cycle. Go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then go to IDLE. No backpressure on the response.
- Latency from accept edge to resp_valid: load 3 cycles, store 2 cycles, error 1 cycle. Throughput: one request per 4 cycles (load) or 3 cycles (store).
- req_valid while busy is ignored; the requester holds it until req_ready=1.
- Misalignment:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - LWL/LWR/LB/LBU/SB are never misaligned.
- Loads: mem_byte_en=4'b1111. Let k=addr[1:0] and w=captured word.
  - LB/LBU: byte w[31-8k -: 8], sign- or zero-extended.
  - LH/LHU: k=0 takes w[31:16]; k=2 takes w[15:0]. Sign- or zero-extended.
  - LW: w.
  - LWL by k:
    - k=0: w
    - k=1: {w[23:0],rt[7:0]}
    - k=2: {w[15:0],rt[15:0]}
    - k=3: {w[7:0],rt[23:0]}
  - LWR by k:
    - k=3: w
    - k=2: {rt[31:24],w[31:8]}
    - k=1: {rt[31:16],w[31:16]}
    - k=0: {rt[31:8],w[31:24]}
- Stores:
  - SB: mem_byte_en = one-hot bit k; mem_wdata = {4{wdata[7:0]}}.
  - SH: k=0 gives 4'b0011, k=2 gives 4'b1100; mem_wdata = {2{wdata[15:0]}}.
  - SW: 4'b1111, wdata unchanged.
- mem_wr_en and mem_read_en are never both high. Outside ISSUE, both strobes are 0; mem_address, mem_byte_en and mem_wdata hold their last values.

Decomposition:
- Package mips_lsu_pkg holds:
  - lsu_op_t (4-bit): LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10. All other codes are illegal.
  - lsu_state_t.
  - Helper functions is_load and is_store.
- Sub-module mips_lsu_align: purely combinational. It computes the misalign flag, store byte_en/wdata, and load extract/merge from op, k, w, rt and wdata.
- The top module holds the FSM and registers only.

Test Plan:
- Memory word at 0x100 = 0x8899AABB. LB 0x101 → 0xFFFFFF99. LBU 0x101 → 0x00000099. LH 0x102 → 0xFFFFAABB. LW 0x100 → 0x8899AABB. Each load: resp_valid exactly 3 cycles after accept; mem_read_en high 1 cycle with mem_address 0x100.
- LWL 0x101 with rt=0x11223344 → 0x99AABB44. LWR 0x101 with rt=0x11223344 → 0x11228899.
- SB 0x103 with wdata=0x000000CC → mem_byte_en 4'b1000, mem_wdata 0xCCCCCCCC. SH 0x102 with wdata=0x0000BEEF → 4'b1100, 0xBEEFBEEF. A following LW 0x100 reads the updated word.
- LW 0x102 and SH 0x101 → resp_err=1 and resp_data=0 one cycle after accept; mem_read_en/mem_wr_en never asserted. Illegal op 7 → resp_err=1.
- req_valid held high during a load: the second request is accepted only after return to IDLE; req_ready=0 throughout.
- Assert reset during WAIT → next cycle all outputs 0, req_ready=1, no resp_valid. A new request then completes normally.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
// Opcode encoding matches the datapath's lsu_op field.
package mips_lsu_pkg;

  localparam int LSU_LANES = 4;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_t;

  function automatic logic is_load(lsu_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction

  function automatic logic is_store(lsu_op_t op);
    return op inside {SB, SH, SW};
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Request/response channel from the datapath plus the data-memory bus.
// slave is the LSU's view; master is the datapath/memory side.
interface mips_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mips_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_rt;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wr_en;
  logic              mem_read_en;
  logic [3:0]        mem_byte_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rt, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wdata
  );

endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: misalignment, big-endian store lanes and
// load extract / sign-extend / LWL-LWR merge.
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] w,
  input  logic [31:0] rt,
  input  logic [31:0] wdata,
  output logic        misalign,
  output logic [3:0]  byte_en,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  // lane[i] is the byte at address offset i (big-endian)
  logic [7:0]  lane [LSU_LANES];
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  generate
    for (genvar gi = 0; gi < LSU_LANES; gi++) begin : g_lane
      assign lane[gi] = w[31-8*gi -: 8];
    end
  endgenerate

  assign b_sel = lane[k];
  assign h_sel = k[1] ? w[15:0] : w[31:16];

  always_comb begin
    misalign = 1'b0;
    byte_en  = is_load(op) ? 4'b1111 : 4'b0000;
    st_wdata = wdata;
    ld_data  = w;
    case (op)
      LB:  ld_data = {{24{b_sel[7]}}, b_sel};
      LBU: ld_data = {24'd0, b_sel};
      LH: begin
        misalign = k[0];
        ld_data  = {{16{h_sel[15]}}, h_sel};
      end
      LHU: begin
        misalign = k[0];
        ld_data  = {16'd0, h_sel};
      end
      LW:  misalign = |k;
      LWL: begin
        case (k)
          2'd0:    ld_data = w;
          2'd1:    ld_data = {w[23:0], rt[7:0]};
          2'd2:    ld_data = {w[15:0], rt[15:0]};
          default: ld_data = {w[7:0], rt[23:0]};
        endcase
      end
      LWR: begin
        case (k)
          2'd3:    ld_data = w;
          2'd2:    ld_data = {rt[31:24], w[31:8]};
          2'd1:    ld_data = {rt[31:16], w[31:16]};
          default: ld_data = {rt[31:8], w[31:24]};
        endcase
      end
      SB: begin
        byte_en  = 4'b0001 << k;
        st_wdata = {4{wdata[7:0]}};
      end
      SH: begin
        misalign = k[0];
        byte_en  = k[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      SW: begin
        misalign = |k;
        byte_en  = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: turns one request into a single aligned memory
// transaction and returns a one-cycle response pulse.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       reset,
  mips_lsu_if.slave bus
);

  lsu_state_t        state_reg, state_next;
  lsu_op_t           op_reg;
  logic [1:0]        k_reg;
  logic [DATA_W-1:0] rt_reg;
  logic [DATA_W-1:0] result_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic [3:0]        mem_byte_en_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_wr_en_reg;
  logic              mem_read_en_reg;

  logic       accept;
  logic       bad_req;
  lsu_op_t    op_sel;
  logic [1:0] k_sel;
  logic       al_misalign;
  logic [3:0] al_byte_en;
  logic [31:0] al_st_wdata;
  logic [31:0] al_ld_data;

  // In IDLE the aligner looks at the live request; afterwards at the latched one
  assign op_sel  = (state_reg == ST_IDLE) ? bus.req_op : op_reg;
  assign k_sel   = (state_reg == ST_IDLE) ? bus.req_addr[1:0] : k_reg;
  assign accept  = (state_reg == ST_IDLE) && bus.req_valid;
  assign bad_req = !(is_load(bus.req_op) || is_store(bus.req_op)) || al_misalign;

  mips_lsu_align u_align (
    .op       (op_sel),
    .k        (k_sel),
    .w        (bus.mem_rdata),
    .rt       (rt_reg),
    .wdata    (bus.req_wdata),
    .misalign (al_misalign),
    .byte_en  (al_byte_en),
    .st_wdata (al_st_wdata),
    .ld_data  (al_ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.req_valid) state_next = bad_req ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_next = is_load(op_reg) ? ST_WAIT : ST_DONE;
      ST_WAIT:  state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg          <= LB;
      k_reg           <= 2'd0;
      rt_reg          <= '0;
      result_reg      <= '0;
      err_reg         <= 1'b0;
      mem_address_reg <= '0;
      mem_byte_en_reg <= 4'b0000;
      mem_wdata_reg   <= '0;
      mem_wr_en_reg   <= 1'b0;
      mem_read_en_reg <= 1'b0;
    end else begin
      mem_wr_en_reg   <= 1'b0;
      mem_read_en_reg <= 1'b0;
      if (accept) begin
        op_reg     <= bus.req_op;
        k_reg      <= bus.req_addr[1:0];
        rt_reg     <= bus.req_rt;
        result_reg <= '0;
        err_reg    <= bad_req;
        // Rejected requests leave the memory-side registers untouched
        if (!bad_req) begin
          mem_address_reg <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          mem_byte_en_reg <= al_byte_en;
          mem_wdata_reg   <= al_st_wdata;
          mem_read_en_reg <= is_load(bus.req_op);
          mem_wr_en_reg   <= is_store(bus.req_op);
        end
      end
      if (state_reg == ST_WAIT) result_reg <= al_ld_data;
    end
  end

  always_comb begin
    bus.req_ready   = (state_reg == ST_IDLE);
    bus.resp_valid  = (state_reg == ST_DONE);
    bus.resp_err    = (state_reg == ST_DONE) && err_reg;
    bus.resp_data   = result_reg;
    bus.mem_address = mem_address_reg;
    bus.mem_byte_en = mem_byte_en_reg;
    bus.mem_wdata   = mem_wdata_reg;
    bus.mem_wr_en   = mem_wr_en_reg;
    bus.mem_read_en = mem_read_en_reg;
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu with a registered-read memory model.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_preload = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mips_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word memory, byte_en bit i writes data[31-8i -: 8]
  logic [31:0] mem [0:255];
  always @(posedge clk) begin : mem_model
    logic [31:0] nw;
    nw = mem[bus.mem_address[9:2]];
    for (int i = 0; i < 4; i++)
      if (bus.mem_byte_en[i]) nw[31-8*i -: 8] = bus.mem_wdata[31-8*i -: 8];
    if (mem_preload) mem[8'h40] <= 32'h8899AABB;
    else if (bus.mem_wr_en) mem[bus.mem_address[9:2]] <= nw;
    if (bus.mem_read_en) bus.mem_rdata <= mem[bus.mem_address[9:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and observe it until the response pulse
  task automatic do_req(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rt, output logic [31:0] data, output logic err,
                        output int lat, output int rd_cnt, output int wr_cnt,
                        output logic [31:0] seen_addr, output logic [3:0] seen_be,
                        output logic [31:0] seen_wd, output int ready_hi);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rt    = rt;
    step();
    bus.req_valid = 1'b0;
    lat = 1; rd_cnt = 0; wr_cnt = 0; ready_hi = 0;
    seen_addr = '0; seen_be = '0; seen_wd = '0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_read_en || bus.mem_wr_en) begin
        seen_addr = bus.mem_address;
        seen_be   = bus.mem_byte_en;
        seen_wd   = bus.mem_wdata;
      end
      rd_cnt += int'(bus.mem_read_en);
      wr_cnt += int'(bus.mem_wr_en);
      ready_hi += int'(bus.req_ready);
      step();
      lat++;
    end
    rd_cnt += int'(bus.mem_read_en);
    wr_cnt += int'(bus.mem_wr_en);
    data = bus.resp_data;
    err  = bus.resp_err;
    step();
  endtask

  task automatic test_reset();
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_wr_en} !== 5'b10000)
      $display("FAIL reset_ctrl: got %b expected 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_wr_en});
    else passed++;
    total++;
    if ({bus.mem_address, bus.mem_byte_en, bus.mem_wdata, bus.resp_data} !== 100'd0)
      $display("FAIL reset_data: got %h expected 0",
               {bus.mem_address, bus.mem_byte_en, bus.mem_wdata, bus.resp_data});
    else passed++;
    @(negedge clk) reset = 1'b0;
    step();
  endtask

  task automatic test_loads();
    lsu_op_t     ops [6] = '{LB, LBU, LH, LW, LWL, LWR};
    logic [31:0] adr [6] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h101, 32'h101};
    logic [31:0] exp [6] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h8899AABB,
                             32'h99AABB44, 32'h11228899};
    logic [31:0] data, sa, swd; logic err; logic [3:0] sbe;
    int lat, rd, wr, rdy;
    for (int i = 0; i < 6; i++) begin
      do_req(ops[i], adr[i], 32'hDEADBEEF, 32'h11223344, data, err, lat, rd, wr, sa, sbe, swd, rdy);
      total++;
      if (data !== exp[i] || err !== 1'b0)
        $display("FAIL load%0d_data: got %h err %b expected %h err 0", i, data, err, exp[i]);
      else passed++;
      total++;
      if (lat !== 3) $display("FAIL load%0d_latency: got %0d expected 3", i, lat);
      else passed++;
      total++;
      if (rd !== 1 || wr !== 0 || sa !== 32'h100 || sbe !== 4'b1111 || rdy !== 0)
        $display("FAIL load%0d_bus: got rd %0d wr %0d addr %h be %b ready %0d expected 1 0 100 1111 0",
                 i, rd, wr, sa, sbe, rdy);
      else passed++;
    end
  endtask

  task automatic test_stores();
    lsu_op_t     ops [2] = '{SB, SH};
    logic [31:0] adr [2] = '{32'h103, 32'h102};
    logic [31:0] wdv [2] = '{32'h000000CC, 32'h0000BEEF};
    logic [3:0]  ebe [2] = '{4'b1000, 4'b1100};
    logic [31:0] ewd [2] = '{32'hCCCCCCCC, 32'hBEEFBEEF};
    logic [31:0] data, sa, swd; logic err; logic [3:0] sbe;
    int lat, rd, wr, rdy;
    for (int i = 0; i < 2; i++) begin
      do_req(ops[i], adr[i], wdv[i], 32'h0, data, err, lat, rd, wr, sa, sbe, swd, rdy);
      total++;
      if (sbe !== ebe[i] || swd !== ewd[i] || sa !== 32'h100)
        $display("FAIL store%0d_lanes: got be %b wd %h addr %h expected %b %h 100",
                 i, sbe, swd, sa, ebe[i], ewd[i]);
      else passed++;
      total++;
      if (lat !== 2 || rd !== 0 || wr !== 1 || data !== 32'h0 || err !== 1'b0)
        $display("FAIL store%0d_resp: got lat %0d rd %0d wr %0d data %h err %b expected 2 0 1 0 0",
                 i, lat, rd, wr, data, err);
      else passed++;
    end
    do_req(LW, 32'h100, 32'h0, 32'h0, data, err, lat, rd, wr, sa, sbe, swd, rdy);
    total++;
    if (data !== 32'h8899BEEF) $display("FAIL store_readback: got %h expected 8899beef", data);
    else passed++;
  endtask

  task automatic test_errors();
    lsu_op_t     ops [3] = '{LW, SH, lsu_op_t'(4'd7)};
    logic [31:0] adr [3] = '{32'h102, 32'h101, 32'h100};
    logic [31:0] data, sa, swd; logic err; logic [3:0] sbe;
    int lat, rd, wr, rdy;
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], adr[i], 32'hFFFFFFFF, 32'hFFFFFFFF, data, err, lat, rd, wr, sa, sbe, swd, rdy);
      total++;
      if (err !== 1'b1 || data !== 32'h0 || lat !== 1)
        $display("FAIL err%0d_resp: got err %b data %h lat %0d expected 1 0 1", i, err, data, lat);
      else passed++;
      total++;
      if (rd !== 0 || wr !== 0)
        $display("FAIL err%0d_strobes: got rd %0d wr %0d expected 0 0", i, rd, wr);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] accepts = '0;
    int resp_cnt = 0, busy_cnt = 0, n = 0;
    logic data_ok = 1'b1;
    logic rdy_before;
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h100;
    bus.req_rt    = 32'h0;
    for (int i = 0; i < 9; i++) begin
      rdy_before = bus.req_ready;
      step();
      accepts[i] = rdy_before;
      busy_cnt += int'(!bus.req_ready);
      if (bus.resp_valid) begin
        resp_cnt++;
        if (bus.resp_data !== 32'h8899BEEF) data_ok = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    while (!bus.req_ready && n < 10) begin step(); n++; end
    total++;
    if (accepts !== 9'b100010001) $display("FAIL b2b_accepts: got %b expected 100010001", accepts);
    else passed++;
    total++;
    if (resp_cnt !== 2 || busy_cnt !== 7 || !data_ok)
      $display("FAIL b2b_resp: got resp %0d busy %0d data_ok %b expected 2 7 1", resp_cnt, busy_cnt, data_ok);
    else passed++;
    total++;
    if (n >= 10) $display("FAIL b2b_drain: got %0d cycles expected under 10", n);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] data, sa, swd; logic err; logic [3:0] sbe;
    int lat, rd, wr, rdy, resp_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h100;
    step();
    bus.req_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_wr_en} !== 5'b10000 ||
        {bus.mem_address, bus.mem_byte_en, bus.mem_wdata, bus.resp_data} !== 100'd0)
      $display("FAIL midreset_outputs: got ctrl %b data %h expected 10000 0",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_wr_en},
               {bus.mem_address, bus.mem_byte_en, bus.mem_wdata, bus.resp_data});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      resp_cnt += int'(bus.resp_valid);
    end
    @(negedge clk) reset = 1'b0;
    step();
    resp_cnt += int'(bus.resp_valid);
    total++;
    if (resp_cnt !== 0 || bus.req_ready !== 1'b1)
      $display("FAIL midreset_noresp: got resp %0d ready %b expected 0 1", resp_cnt, bus.req_ready);
    else passed++;
    do_req(LW, 32'h100, 32'h0, 32'h0, data, err, lat, rd, wr, sa, sbe, swd, rdy);
    total++;
    if (data !== 32'h8899BEEF || err !== 1'b0 || lat !== 3)
      $display("FAIL midreset_recover: got %h err %b lat %0d expected 8899beef 0 3", data, err, lat);
    else passed++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = LB;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rt    = '0;
    mem_preload   = 1'b1;
    step();
    step();
    mem_preload = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
